// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor error monitor.
package sensor_pkg;

    localparam int NUM_SENSORS = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        QUALIFY      = 2'd1,
        ALARM        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-stage synchronizer; all bits travel together so a bus stays aligned.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back flop stages, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/sensor_error_monitor.sv
// Synchronizes and debounces the sensor error flag, raises a latched alarm,
// snapshots the sensor bus on confirmation and counts confirmed events.
module sensor_error_monitor
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   error_in,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic                   alarm,
    output logic [NUM_SENSORS-1:0] alarm_sensors,
    output logic [CNT_WIDTH-1:0]   event_count,
    output logic                   busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [CNT_WIDTH-1:0] EVT_MAX = {CNT_WIDTH{1'b1}};

    logic [NUM_SENSORS:0]   sync_in_s;
    logic [NUM_SENSORS:0]   sync_out_s;
    logic                   s_err_s;
    logic [NUM_SENSORS-1:0] s_sens_s;

    state_t                 state_r;
    logic [DW-1:0]          cnt_r;
    logic                   alarm_r;
    logic                   busy_r;
    logic [NUM_SENSORS-1:0] snap_r;
    logic [CNT_WIDTH-1:0]   evt_r;

    assign sync_in_s = {error_in, sensors};

    sync_2ff #(
        .WIDTH(NUM_SENSORS + 1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (sync_in_s),
        .q  (sync_out_s)
    );

    assign s_err_s  = sync_out_s[NUM_SENSORS];
    assign s_sens_s = sync_out_s[NUM_SENSORS-1:0];

    // Debounce FSM with registered alarm/busy, snapshot and saturating event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {DW{1'b0}};
            alarm_r <= 1'b0;
            busy_r  <= 1'b0;
            snap_r  <= {NUM_SENSORS{1'b0}};
            evt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    alarm_r <= 1'b0;
                    if (s_err_s) begin
                        state_r <= QUALIFY;
                        cnt_r   <= CNT_ONE;
                        busy_r  <= 1'b1;
                    end else begin
                        cnt_r   <= {DW{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                QUALIFY: begin
                    if (!s_err_s) begin
                        // Glitch shorter than the debounce window: drop silently.
                        state_r <= IDLE;
                        cnt_r   <= {DW{1'b0}};
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ALARM;
                        cnt_r   <= {DW{1'b0}};
                        alarm_r <= 1'b1;
                        snap_r  <= s_sens_s;
                        if (evt_r != EVT_MAX) begin
                            evt_r <= evt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            evt_r <= evt_r;
                        end
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ALARM: begin
                    if (clear) begin
                        alarm_r <= 1'b0;
                        if (s_err_s) begin
                            // Fault still present: wait for it to go away before re-arming.
                            state_r <= WAIT_RELEASE;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        alarm_r <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    alarm_r <= 1'b0;
                    if (!s_err_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {DW{1'b0}};
                    alarm_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign alarm         = alarm_r;
    assign busy          = busy_r;
    assign alarm_sensors = snap_r;
    assign event_count   = evt_r;

endmodule

// File: tb/tb_sensor_error_monitor.sv
// Directed bench for sensor_error_monitor: default instance plus a 2-bit counter instance.
module tb_sensor_error_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       error_in;
    logic [3:0] sensors;
    logic       clear;

    logic       alarm_a, busy_a;
    logic [3:0] asens_a;
    logic [7:0] cnt_a;
    logic       alarm_b, busy_b;
    logic [3:0] asens_b;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sensor_error_monitor #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .error_in(error_in), .sensors(sensors), .clear(clear),
        .alarm(alarm_a), .alarm_sensors(asens_a), .event_count(cnt_a), .busy(busy_a)
    );

    sensor_error_monitor #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .error_in(error_in), .sensors(sensors), .clear(clear),
        .alarm(alarm_b), .alarm_sensors(asens_b), .event_count(cnt_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full event: hold fault long enough to confirm, release it, then acknowledge.
    task automatic confirm_event(input logic [3:0] s);
        sensors  = s;
        error_in = 1'b1;
        repeat (6) tick();
        error_in = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    logic seen_alarm, seen_busy;

    initial begin
        rst = 1'b1; error_in = 1'b1; sensors = 4'b0000; clear = 1'b0;

        // Reset held 2 cycles with error_in high
        repeat (2) tick();
        chk("rst_alarm", 32'(alarm_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_snap",  32'(asens_a), 32'd0);
        chk("rst_busy",  32'(busy_a), 32'd0);

        // Alarm on the 6th edge after reset release
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_alarm_e5", 32'(alarm_a), 32'd0);
        chk("post_rst_busy_e5",  32'(busy_a), 32'd1);
        tick();
        chk("post_rst_alarm_e6", 32'(alarm_a), 32'd1);
        chk("post_rst_count",    32'(cnt_a), 32'd1);

        // Fault goes away while in ALARM: alarm holds until clear
        error_in = 1'b0;
        repeat (4) tick();
        chk("alarm_hold_no_clear", 32'(alarm_a), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_gone_alarm", 32'(alarm_a), 32'd0);
        chk("clear_gone_busy",  32'(busy_a), 32'd0);

        // Glitch rejection: 3-cycle pulse
        seen_alarm = 1'b0; seen_busy = 1'b0;
        error_in = 1'b1;
        repeat (3) begin
            tick();
            seen_alarm |= alarm_a; seen_busy |= busy_a;
        end
        error_in = 1'b0;
        repeat (8) begin
            tick();
            seen_alarm |= alarm_a; seen_busy |= busy_a;
        end
        chk("glitch_no_alarm",   32'(seen_alarm), 32'd0);
        chk("glitch_busy_pulse", 32'(seen_busy), 32'd1);
        chk("glitch_busy_end",   32'(busy_a), 32'd0);
        chk("glitch_count",      32'(cnt_a), 32'd1);

        // Clear ignored in IDLE
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("idle_clear_busy", 32'(busy_a), 32'd0);

        // Confirmation with snapshot
        sensors = 4'b0110; error_in = 1'b1;
        repeat (5) tick();
        chk("conf_alarm_e5", 32'(alarm_a), 32'd0);
        tick();
        chk("conf_alarm_e6", 32'(alarm_a), 32'd1);
        chk("conf_snap",     32'(asens_a), 32'h6);
        chk("conf_count",    32'(cnt_a), 32'd2);

        // Clear while fault persists -> WAIT_RELEASE, no recount
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("wr_alarm", 32'(alarm_a), 32'd0);
        chk("wr_busy",  32'(busy_a), 32'd1);
        repeat (6) tick();
        chk("wr_hold_alarm", 32'(alarm_a), 32'd0);
        chk("wr_hold_count", 32'(cnt_a), 32'd2);
        chk("wr_snap_kept",  32'(asens_a), 32'h6);
        error_in = 1'b0;
        repeat (3) tick();
        chk("wr_release_busy", 32'(busy_a), 32'd0);

        // Re-assert for a new event with a different snapshot
        sensors = 4'b1001; error_in = 1'b1;
        repeat (6) tick();
        chk("re_alarm", 32'(alarm_a), 32'd1);
        chk("re_count", 32'(cnt_a), 32'd3);
        chk("re_snap",  32'(asens_a), 32'h9);
        error_in = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();

        // Saturation on the 2-bit counter after 5 events
        chk("sat3_count_b", 32'(cnt_b), 32'd3);
        confirm_event(4'b0011);
        confirm_event(4'b1100);
        chk("sat5_count_a", 32'(cnt_a), 32'd5);
        chk("sat5_count_b", 32'(cnt_b), 32'd3);
        chk("sat5_snap_b",  32'(asens_b), 32'hC);

        // Reset during QUALIFY discards progress and the count
        error_in = 1'b1;
        repeat (3) tick();
        chk("mid_q_busy", 32'(busy_b), 32'd1);
        rst = 1'b1; error_in = 1'b0;
        tick();
        chk("mid_rst_count_a", 32'(cnt_a), 32'd0);
        chk("mid_rst_count_b", 32'(cnt_b), 32'd0);
        chk("mid_rst_snap_b",  32'(asens_b), 32'd0);
        rst = 1'b0;
        seen_alarm = 1'b0;
        repeat (10) begin
            tick();
            seen_alarm |= alarm_a | alarm_b;
        end
        chk("mid_rst_no_alarm", 32'(seen_alarm), 32'd0);
        chk("mid_rst_busy",     32'(busy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_error_monitor.md
Name: sensor_error_monitor

Overview:
- Downstream consumer of the combinational sensor-error detector output (error = s0 | s1&s2 | s1&s3).
- Synchronizes the raw error flag and the 4-bit sensor bus, then debounces the error: it must persist DEBOUNCE_CYCLES consecutive cycles before an alarm is raised.
- Latches a sensor snapshot and counts confirmed events. The alarm holds until cleared by software or the host.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high samples required to confirm an error; legal range >= 2.
- CNT_WIDTH, 8, width of the saturating event counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset. Synchronous, active-high.
- error_in  input  1  raw error flag from the upstream combinational detector.
- sensors  input  4  raw sensor bus; the same vector that feeds the detector.
- clear  input  1  single-cycle alarm acknowledge.
- alarm  output  1  confirmed-error alarm; registered.
- alarm_sensors  output  4  synchronized sensor vector captured at confirmation.
- event_count  output  CNT_WIDTH  number of confirmed events; saturating.
- busy  output  1  high in QUALIFY, ALARM or WAIT_RELEASE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Synchronizer flops clear to 0.
  - State goes to IDLE; debounce count goes to 0.
  - alarm, alarm_sensors, event_count and busy all read 0 the cycle after the edge.
  - Reset mid-QUALIFY or mid-ALARM discards all progress. event_count is cleared too.
- Synchronizer:
  - error_in and sensors pass together through 2 flop stages (5 bits wide), so they stay aligned. The outputs are s_err and s_sens.
  - Input-to-FSM latency is 2 cycles.
- States: IDLE, QUALIFY, ALARM, WAIT_RELEASE.
  - IDLE: if s_err=1, go to QUALIFY and set cnt=1. Otherwise stay.
  - QUALIFY, s_err=0: go to IDLE, cnt=0. A glitch produces no alarm and no count.
  - QUALIFY, s_err=1 and cnt==DEBOUNCE_CYCLES-1: go to ALARM. On the same edge, alarm_sensors<=s_sens and event_count increments. event_count saturates at 2^CNT_WIDTH-1 and does not wrap.
  - QUALIFY, s_err=1 otherwise: cnt++.
  - ALARM: alarm=1. On clear=1, go to WAIT_RELEASE if s_err=1, else to IDLE. Without clear, stay, even if s_err drops.
  - WAIT_RELEASE: alarm=0. Go to IDLE when s_err=0. A persistent fault is therefore counted once, not re-alarmed repeatedly.
- alarm and busy are decoded from registered state. No combinational path from inputs to outputs.
- Timing: error_in is first sampled high at edge k and held. alarm rises after edge k+DEBOUNCE_CYCLES+1, which is 6 edges for the default.
- alarm_sensors holds its value until the next confirmation or reset. It is not cleared by clear.
- clear in IDLE, QUALIFY or WAIT_RELEASE is ignored.
- Simultaneous clear and s_err=1 in ALARM goes to WAIT_RELEASE.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES)+1.

Decomposition:
- Package sensor_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, QUALIFY, ALARM, WAIT_RELEASE});
  - the localparam NUM_SENSORS=4.
- One sub-module, sync_2ff, parameterized by WIDTH. It is instantiated once here with WIDTH=5 and is reusable elsewhere.
- FSM, debounce counter, snapshot register and event counter stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with error_in=1 -> alarm=0, event_count=0, alarm_sensors=0, busy=0. After rst falls, alarm rises 6 edges later (default parameters).
- Glitch rejection: error_in=1 for 3 cycles, then 0 -> alarm never asserts, event_count stays 0, busy pulses then returns to 0.
- Confirmation and snapshot: sensors=4'b0110, error_in=1, held -> alarm=1 and alarm_sensors=4'b0110 after edge k+5; event_count=1.
- Clear with fault persisting: pulse clear while error_in=1 -> alarm falls next cycle, state is WAIT_RELEASE and no recount. Drop error_in -> IDLE 2 cycles later. Reassert for 4 or more cycles -> event_count=2.
- Clear after fault gone: error_in drops while in ALARM -> alarm stays 1. Clear pulse -> alarm=0, IDLE, busy=0.
- Saturation and reset mid-operation, with CNT_WIDTH=2:
  - 5 confirmed events -> event_count=3 and holds.
  - Assert rst during QUALIFY -> event_count=0 and no alarm follows.
